// File: rtl/dual_input_debouncer_if.sv
// Interface bundling the raw inputs, glitch clear and conditioned outputs of the
// dual-channel debouncer. Clock and reset stay plain ports on the module.
interface dual_input_debouncer_if #(
  parameter int unsigned GLITCH_W = 8
);
  logic                data_in1;
  logic                data_in2;
  logic                glitch_clr;
  logic                data_out1;
  logic                data_out2;
  logic [GLITCH_W-1:0] glitch_cnt1;
  logic [GLITCH_W-1:0] glitch_cnt2;

  // Driver side: produces raw inputs, observes conditioned outputs.
  modport master (
    output data_in1,
    output data_in2,
    output glitch_clr,
    input  data_out1,
    input  data_out2,
    input  glitch_cnt1,
    input  glitch_cnt2
  );

  // Debouncer side.
  modport slave (
    input  data_in1,
    input  data_in2,
    input  glitch_clr,
    output data_out1,
    output data_out2,
    output glitch_cnt1,
    output glitch_cnt2
  );
endinterface

// File: rtl/dual_input_debouncer.sv
// Two independent input conditioners: synchroniser chain followed by a debounce FSM
// that only moves the output after DEBOUNCE_CYCLES stable samples. Rejected pulses
// are tallied in saturating per-channel counters.
module dual_input_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GLITCH_W        = 8
) (
  input logic                         clk,
  input logic                         rst_n,
  dual_input_debouncer_if.slave       dbus
);

  localparam int unsigned           CntW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0]       CntLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0]   GlitchMax = '1;

  typedef enum logic [1:0] {
    StStableLow,
    StChkHigh,
    StStableHigh,
    StChkLow
  } state_e;

  logic [1:0] raw;
  assign raw = {dbus.data_in2, dbus.data_in1};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   glitch_inc;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;

    // Synchroniser chain; bit 0 samples the asynchronous raw input.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[c]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce next-state: a CHK state either confirms the new level or falls back.
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      out_d      = out_q;
      glitch_inc = 1'b0;
      unique case (state_q)
        StStableLow: begin
          if (s) begin
            state_d = StChkHigh;
            cnt_d   = CntW'(1);
          end
        end
        StChkHigh: begin
          if (!s) begin
            state_d    = StStableLow;
            glitch_inc = 1'b1;
          end else if (cnt_q == CntLast) begin
            state_d = StStableHigh;
            out_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StStableHigh: begin
          if (!s) begin
            state_d = StChkLow;
            cnt_d   = CntW'(1);
          end
        end
        StChkLow: begin
          if (s) begin
            state_d    = StStableHigh;
            glitch_inc = 1'b1;
          end else if (cnt_q == CntLast) begin
            state_d = StStableLow;
            out_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StStableLow;
        end
      endcase
    end

    // Glitch counter: clear beats increment; increment saturates.
    always_comb begin
      glitch_d = glitch_q;
      if (dbus.glitch_clr) begin
        glitch_d = '0;
      end else if (glitch_inc && (glitch_q != GlitchMax)) begin
        glitch_d = glitch_q + GLITCH_W'(1);
      end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q  <= StStableLow;
        cnt_q    <= '0;
        out_q    <= 1'b0;
        glitch_q <= '0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        out_q    <= out_d;
        glitch_q <= glitch_d;
      end
    end
  end

  assign dbus.data_out1   = g_ch[0].out_q;
  assign dbus.data_out2   = g_ch[1].out_q;
  assign dbus.glitch_cnt1 = g_ch[0].glitch_q;
  assign dbus.glitch_cnt2 = g_ch[1].glitch_q;

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Bench for dual_input_debouncer: a table of reset/latency/glitch vectors, hand-written
// multi-cycle corner sequences, then randomized stimulus checked against a run-length model.
module tb_dual_input_debouncer;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned GW   = 8;
  localparam int          GMAX = (1 << GW) - 1;

  logic clk;
  logic rst_n;

  dual_input_debouncer_if #(.GLITCH_W(GW)) dif ();

  dual_input_debouncer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .GLITCH_W       (GW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dbus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the output follows s only once s has disagreed with it for DEB
  // consecutive samples; an interrupted disagreement run is one glitch.
  bit dly0[$];
  bit dly1[$];
  int run_m[2];
  bit out_m[2];
  int gl_m[2];

  function automatic void model_chan(int c, bit s);
    if (s != out_m[c]) begin
      run_m[c]++;
      if (run_m[c] == DEB) begin
        out_m[c] = s;
        run_m[c] = 0;
      end
    end else if (run_m[c] > 0) begin
      run_m[c] = 0;
      if (gl_m[c] < GMAX) gl_m[c]++;
    end
  endfunction

  function automatic void model_edge(bit rst, bit i1, bit i2, bit clr);
    bit s0, s1;
    if (!rst) begin
      dly0 = {};
      dly1 = {};
      for (int i = 0; i < SYNC; i++) begin
        dly0.push_back(1'b0);
        dly1.push_back(1'b0);
      end
      for (int c = 0; c < 2; c++) begin
        run_m[c] = 0;
        out_m[c] = 1'b0;
        gl_m[c]  = 0;
      end
    end else begin
      s0 = dly0.pop_front();
      s1 = dly1.pop_front();
      dly0.push_back(i1);
      dly1.push_back(i2);
      model_chan(0, s0);
      model_chan(1, s1);
      if (clr) begin
        gl_m[0] = 0;
        gl_m[1] = 0;
      end
    end
  endfunction

  // One clock: drive at negedge, advance model at posedge, sample 1 time unit later.
  task automatic step(input bit rst, input bit i1, input bit i2, input bit clr);
    @(negedge clk);
    rst_n          = rst;
    dif.data_in1   = i1;
    dif.data_in2   = i2;
    dif.glitch_clr = clr;
    @(posedge clk);
    model_edge(rst, i1, i2, clr);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out1"}, int'(dif.data_out1), int'(out_m[0]));
    check({tag, ".out2"}, int'(dif.data_out2), int'(out_m[1]));
    check({tag, ".g1"}, int'(dif.glitch_cnt1), gl_m[0]);
    check({tag, ".g2"}, int'(dif.glitch_cnt2), gl_m[1]);
  endtask

  typedef struct {
    bit rst;
    bit i1;
    bit i2;
    bit clr;
    bit o1;
    bit o2;
    int g1;
    int g2;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, bit rst, bit i1, bit i2, bit clr,
                              bit o1, bit o2, int g1, int g2);
    vec_t v;
    v = '{rst: rst, i1: i1, i2: i2, clr: clr, o1: o1, o2: o2, g1: g1, g2: g2};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  initial begin
    bit r1, r2;

    rst_n          = 1'b0;
    dif.data_in1   = 1'b0;
    dif.data_in2   = 1'b0;
    dif.glitch_clr = 1'b0;

    // Reset with inputs high, rise after 5 edges, channel-1 fall, 2- and 3-cycle glitches.
    add(2, 0, 1, 1, 0, 0, 0, 0, 0);
    add(5, 1, 1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 1, 1, 0, 0);
    add(5, 1, 0, 1, 0, 1, 1, 0, 0);
    add(2, 1, 0, 1, 0, 0, 1, 0, 0);
    add(2, 1, 1, 1, 0, 0, 1, 0, 0);
    add(2, 1, 0, 1, 0, 0, 1, 0, 0);
    add(2, 1, 0, 1, 0, 0, 1, 1, 0);
    add(3, 1, 1, 1, 0, 0, 1, 1, 0);
    add(2, 1, 0, 1, 0, 0, 1, 1, 0);
    add(2, 1, 0, 1, 0, 0, 1, 2, 0);
    add(1, 1, 0, 1, 1, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].i1, vecs[i].i2, vecs[i].clr);
      check($sformatf("vec%0d.out1", i), int'(dif.data_out1), int'(vecs[i].o1));
      check($sformatf("vec%0d.out2", i), int'(dif.data_out2), int'(vecs[i].o2));
      check($sformatf("vec%0d.g1", i), int'(dif.glitch_cnt1), vecs[i].g1);
      check($sformatf("vec%0d.g2", i), int'(dif.glitch_cnt2), vecs[i].g2);
    end

    // Channel independence: ch1 rises while ch2 pulses for one cycle on the same edge.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    repeat (4) step(1, 1, 0, 0);
    check("indep.out1_k4", int'(dif.data_out1), 0);
    step(1, 1, 0, 0);
    check("indep.out1_k5", int'(dif.data_out1), 1);
    check("indep.out2", int'(dif.data_out2), 0);
    check("indep.g1", int'(dif.glitch_cnt1), 0);
    check("indep.g2", int'(dif.glitch_cnt2), 1);

    // Saturation after 300 one-cycle glitches, then clear coincident with a reject.
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 1, 0);
      step(1, 1, 0, 0);
    end
    repeat (4) step(1, 1, 0, 0);
    check("sat.g2", int'(dif.glitch_cnt2), GMAX);
    check("sat.out2", int'(dif.data_out2), 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    check("clr_wins.g2", int'(dif.glitch_cnt2), 0);
    step(1, 1, 0, 0);
    check("clr_hold.g2", int'(dif.glitch_cnt2), 0);
    check("clr_hold.out1", int'(dif.data_out1), 1);

    // Reset mid-check, then full latency again with input still high.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    repeat (4) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("midrst.out1", int'(dif.data_out1), 0);
    repeat (5) step(1, 1, 0, 0);
    check("midrst.out1_m4", int'(dif.data_out1), 0);
    step(1, 1, 0, 0);
    check("midrst.out1_m5", int'(dif.data_out1), 1);
    check_model("midrst");

    // Randomized run against the reference model.
    r1 = 1'b0;
    r2 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) r1 = ~r1;
      if ($urandom_range(0, 3) == 0) r2 = ~r2;
      step(($urandom_range(0, 299) != 0), r1, r2, ($urandom_range(0, 79) == 0));
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
